// File: rtl/maxpool_stream.sv
// Streaming max-pool: folds each run of WIN accepted beats into one beat of per-lane maxima plus the winning beat index.
// Latency: result registered 1 cycle after the last beat of a window is accepted; back-to-back windows give one result per WIN beats.
// Backpressure: in_ready = !out_valid || out_ready, so the whole input side stalls while an unread result is held.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of the partial window (held result untouched)
//   in_valid/in_ready   input handshake, in_data = LANES packed DATA_W samples
//   out_valid/out_ready output handshake, out_data = per-lane maxima, out_idx = per-lane beat index of the max
module maxpool_stream #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int WIN    = 4,
   parameter int SIGNED = 1,
   localparam int IDX_W = $clog2(WIN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES*IDX_W-1:0]  out_idx
);

   // cnt is the beat position inside the current window (0 = idle / next beat opens a window)
   logic [IDX_W-1:0]              cnt;
   logic [LANES-1:0][DATA_W-1:0]  acc;
   logic [LANES-1:0][DATA_W-1:0]  nxt_acc;
   logic [LANES-1:0][IDX_W-1:0]   idx;
   logic [LANES-1:0][IDX_W-1:0]   nxt_idx;
   logic                          accept;
   logic                          last;

   // Strict greater-than so that ties keep the earlier beat index.
   function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (SIGNED != 0)
         return $signed(a) > $signed(b);
      else
         return a > b;
   endfunction

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign last     = (cnt == IDX_W'(WIN - 1));

   // Running max including the beat being offered this cycle; the final beat's
   // compare feeds the output register directly, so no extra cycle is spent.
   always_comb begin
      nxt_acc = acc;
      nxt_idx = idx;
      for (int i = 0; i < LANES; i++) begin
         if (cnt == '0) begin
            nxt_acc[i] = in_data[i*DATA_W +: DATA_W];
            nxt_idx[i] = '0;
         end else if (gt(in_data[i*DATA_W +: DATA_W], acc[i])) begin
            nxt_acc[i] = in_data[i*DATA_W +: DATA_W];
            nxt_idx[i] = cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
         idx <= '0;
      end else if (clear) begin
         // A beat accepted alongside clear is dropped; acc is simply reloaded by the next beat 0.
         cnt <= '0;
      end else if (accept) begin
         acc <= nxt_acc;
         idx <= nxt_idx;
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   // Loading a new result takes priority over the drain, which removes the
   // bubble between consecutive windows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else if (accept && last && !clear) begin
         out_valid <= 1'b1;
         out_data  <= nxt_acc;
         out_idx   <= nxt_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;

   typedef struct {
      logic [31:0] ds;
      logic [7:0]  is;
      logic [31:0] du;
      logic [7:0]  iu;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        in_ready_s, in_ready_u;
   logic        out_valid_s, out_valid_u;
   logic [31:0] out_data_s, out_data_u;
   logic [7:0]  out_idx_s, out_idx_u;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   int   pop_cyc[$];

   maxpool_stream #(.DATA_W(8), .LANES(4), .WIN(4), .SIGNED(1)) u_s (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
      .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_idx(out_idx_s)
   );

   maxpool_stream #(.DATA_W(8), .LANES(4), .WIN(4), .SIGNED(0)) u_u (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
      .out_valid(out_valid_u), .out_ready(out_ready),
      .out_data(out_data_u), .out_idx(out_idx_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Lanes 1..3 carry a fixed pattern (rising, falling, constant) so every
   // window's expectation differs only in lane 0.
   function automatic logic [31:0] mkbeat(input logic [7:0] l0, input int k);
      logic [7:0] l1, l2;
      l1 = 8'(k + 1);
      l2 = 8'(4 - k);
      return {8'h55, l2, l1, l0};
   endfunction

   function automatic logic [31:0] xdata(input logic [7:0] l0);
      return {8'h55, 8'h04, 8'h04, l0};
   endfunction

   function automatic logic [7:0] xidx(input logic [1:0] i0);
      return {2'd0, 2'd0, 2'd3, i0};
   endfunction

   // Monitor: samples after the bench has driven the negedge values, i.e. what the next posedge will see.
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst_n && out_valid_s && out_ready) begin
         pop_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result got data %h idx %h", out_data_s, out_idx_s);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data_signed", out_data_s, e.ds);
            chk("out_idx_signed", {24'd0, out_idx_s}, {24'd0, e.is});
            chk("out_valid_unsigned", {31'd0, out_valid_u}, 32'd1);
            chk("out_data_unsigned", out_data_u, e.du);
            chk("out_idx_unsigned", {24'd0, out_idx_u}, {24'd0, e.iu});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [7:0] l0, input int k);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = mkbeat(l0, k);
      for (int t = 0; t < 50 && !acc; t++) begin
         #1;
         acc = in_ready_s;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got in_ready 0 expected 1");
      end
   endtask

   task automatic send_window(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] es, input logic [1:0] eis,
                              input logic [7:0] eu, input logic [1:0] eiu,
                              input bit push);
      exp_t e;
      e.ds = xdata(es);
      e.is = xidx(eis);
      e.du = xdata(eu);
      e.iu = xidx(eiu);
      if (push) exp_q.push_back(e);
      send_beat(b0, 0);
      send_beat(b1, 1);
      send_beat(b2, 2);
      send_beat(b3, 3);
      #1;
      chk("latency_out_valid", {31'd0, out_valid_s}, 32'd1);
   endtask

   initial begin
      int npop;
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #3;
      chk("reset_out_valid", {31'd0, out_valid_s}, 32'd0);
      chk("reset_out_data", out_data_s, 32'd0);
      chk("reset_out_idx", {24'd0, out_idx_s}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready_s}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Signed max 7 at beat 2; unsigned sees 0xFD at beat 1. Result exactly one cycle after 4th accept.
      begin
         exp_t e;
         e.ds = xdata(8'h07); e.is = xidx(2'd2);
         e.du = xdata(8'hFD); e.iu = xidx(2'd1);
         exp_q.push_back(e);
      end
      send_beat(8'h05, 0);
      send_beat(8'hFD, 1);
      send_beat(8'h07, 2);
      #1;
      chk("before_last_out_valid", {31'd0, out_valid_s}, 32'd0);
      send_beat(8'h02, 3);
      #1;
      chk("latency_out_valid", {31'd0, out_valid_s}, 32'd1);

      // Sign-sensitive ordering, then tie resolution to the earlier index.
      send_window(8'h80, 8'h7F, 8'h01, 8'h00, 8'h7F, 2'd1, 8'h80, 2'd0, 1'b1);
      send_window(8'h03, 8'h09, 8'h09, 8'h01, 8'h09, 2'd1, 8'h09, 2'd1, 1'b1);
      repeat (3) @(negedge clk);

      // Hold result for 10 cycles with the next beat waiting, then stream three windows.
      out_ready = 1'b0;
      send_window(8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 2'd3, 8'h40, 2'd3, 1'b1);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = mkbeat(8'h11, 0);
         #1;
         chk("hold_in_ready", {31'd0, in_ready_s}, 32'd0);
         chk("hold_out_valid", {31'd0, out_valid_s}, 32'd1);
         chk("hold_out_data", out_data_s, xdata(8'h40));
         @(negedge clk);
      end
      npop = pop_cyc.size();
      out_ready = 1'b1;
      send_window(8'h11, 8'h44, 8'h22, 8'h33, 8'h44, 2'd1, 8'h44, 2'd1, 1'b1);
      send_window(8'hF0, 8'h05, 8'hF1, 8'h06, 8'h06, 2'd3, 8'hF1, 2'd2, 1'b1);
      send_window(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 2'd0, 1'b1);
      repeat (4) @(negedge clk);
      if (pop_cyc.size() < npop + 4) begin
         checks++;
         errors++;
         $display("FAIL stream_result_count got %0d expected %0d", pop_cyc.size() - npop, 4);
      end else begin
         for (int j = 0; j < 3; j++)
            chk("stream_interval", 32'(pop_cyc[npop+j+1] - pop_cyc[npop+j]), 32'd4);
      end

      // Clear after two beats; the beat offered during clear is dropped too.
      send_beat(8'h70, 0);
      send_beat(8'h60, 1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = mkbeat(8'h7F, 2);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      send_window(8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 2'd3, 8'h04, 2'd3, 1'b1);
      repeat (3) @(negedge clk);

      // Async reset while a result is held, then again mid-window.
      out_ready = 1'b0;
      send_window(8'h7E, 8'h00, 8'h00, 8'h00, 8'h7E, 2'd0, 8'h7E, 2'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_hold_out_valid_s", {31'd0, out_valid_s}, 32'd0);
      chk("rst_hold_out_valid_u", {31'd0, out_valid_u}, 32'd0);
      chk("rst_hold_out_data", out_data_s, 32'd0);
      chk("rst_hold_out_idx", {24'd0, out_idx_s}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send_beat(8'h7E, 0);
      send_beat(8'h7D, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", {31'd0, in_ready_s}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send_window(8'h81, 8'h02, 8'h83, 8'h04, 8'h04, 2'd3, 8'h83, 2'd2, 1'b1);

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain_pending", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
